// File: rtl/blue_player_hit_ctrl.sv
// Blue player hit controller: per-frame blast collision, lives, invulnerability.
// Ports: clk, resetN, startOfFrame, OneSecPulse, player_DR, blast_DR,
//        score_reset -> lives_left, player_hit, invulnerable,
//        player_visible, game_over.
module blue_player_hit_ctrl #(
    parameter int STARTING_LIVES = 3,
    parameter int INVULN_SECONDS = 3,
    parameter int BLINK_FRAMES   = 4
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       OneSecPulse,
    input  logic       player_DR,
    input  logic       blast_DR,
    input  logic       score_reset,
    output logic [2:0] lives_left,
    output logic       player_hit,
    output logic       invulnerable,
    output logic       player_visible,
    output logic       game_over
);

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } state_t;

    localparam logic [2:0] LIVES_INIT = 3'(STARTING_LIVES);
    localparam logic [3:0] SEC_LAST   = 4'(INVULN_SECONDS - 1);
    localparam logic [3:0] BLINK_LAST = 4'(BLINK_FRAMES - 1);

    state_t     r_state, w_state_n;
    logic [2:0] r_lives, w_lives_n;
    logic       r_hit, w_hit_n;
    logic       r_visible, w_visible_n;
    logic       r_pending, w_pending_n;
    logic [3:0] r_sec, w_sec_n;
    logic [3:0] r_frame, w_frame_n;
    logic       w_overlap;
    logic       w_frame_hit;

    assign w_overlap   = player_DR & blast_DR;
    // The overlap on the SOF pixel itself still belongs to the ending frame.
    assign w_frame_hit = r_pending | w_overlap;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state   <= ALIVE;
            r_lives   <= LIVES_INIT;
            r_hit     <= 1'b0;
            r_visible <= 1'b1;
            r_pending <= 1'b0;
            r_sec     <= 4'd0;
            r_frame   <= 4'd0;
        end else begin
            r_state   <= w_state_n;
            r_lives   <= w_lives_n;
            r_hit     <= w_hit_n;
            r_visible <= w_visible_n;
            r_pending <= w_pending_n;
            r_sec     <= w_sec_n;
            r_frame   <= w_frame_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_lives_n   = r_lives;
        w_hit_n     = 1'b0;
        w_visible_n = r_visible;
        w_pending_n = r_pending;
        w_sec_n     = r_sec;
        w_frame_n   = r_frame;
        if (score_reset) begin
            w_state_n   = ALIVE;
            w_lives_n   = LIVES_INIT;
            w_visible_n = 1'b1;
            w_pending_n = 1'b0;
            w_sec_n     = 4'd0;
            w_frame_n   = 4'd0;
        end else begin
            unique case (r_state)
                ALIVE: begin
                    if (startOfFrame) begin
                        w_pending_n = 1'b0;
                        if (w_frame_hit) begin
                            w_hit_n   = 1'b1;
                            w_lives_n = r_lives - 3'd1;
                            if (r_lives <= 3'd1) begin
                                w_state_n   = DEAD;
                                w_lives_n   = 3'd0;
                                w_visible_n = 1'b0;
                            end else begin
                                w_state_n   = INVULN;
                                w_sec_n     = 4'd0;
                                w_frame_n   = 4'd0;
                                w_visible_n = 1'b0;
                            end
                        end
                    end else if (w_overlap) begin
                        w_pending_n = 1'b1;
                    end
                end
                INVULN: begin
                    w_pending_n = 1'b0;
                    if (OneSecPulse) begin
                        w_sec_n = r_sec + 4'd1;
                    end
                    if (startOfFrame) begin
                        if (r_frame == BLINK_LAST) begin
                            w_frame_n   = 4'd0;
                            w_visible_n = ~r_visible;
                        end else begin
                            w_frame_n = r_frame + 4'd1;
                        end
                    end
                    // Leaving the window wins over a same-cycle blink toggle.
                    if (OneSecPulse && (r_sec == SEC_LAST)) begin
                        w_state_n   = ALIVE;
                        w_visible_n = 1'b1;
                    end
                end
                DEAD: begin
                    w_lives_n   = 3'd0;
                    w_visible_n = 1'b0;
                    w_pending_n = 1'b0;
                end
                default: begin
                    w_state_n = ALIVE;
                end
            endcase
        end
    end

    assign lives_left     = r_lives;
    assign player_hit     = r_hit;
    assign invulnerable   = (r_state == INVULN);
    assign player_visible = r_visible;
    assign game_over      = (r_state == DEAD);

endmodule
